qsn_merge_pc5: RTL and testbench
================================

Name: qsn_merge_pc5

Overview:
- Output merge stage of the Pc=5 quasi-cyclic shift network (QSN).
- Consumes the 4-element left-network output and the 5-element right-network output, then selects per element according to the circulant shift factor.
- Produces the fully cyclically shifted 5-element message vector.
- Two registered pipeline stages with valid/ready backpressure; feeds the VNU/CNU message routing.

Parameters:
- PC, 5, circulant sub-matrix size (element count); fixed at 5 for this instance.
- MSG_W, 1, width in bits of each message element.
- SHIFT_W, 3, width of the shift factor.

Ports:
- sys_clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous active-low reset.
- left_in  input  4*MSG_W  left-network outputs; element k holds in[k+s] for k < 5-s.
- right_in  input  5*MSG_W  right-network outputs; element k holds in[k-(5-s)] for k >= 5-s. For s=0, element 4 holds in[4].
- shift_in  input  SHIFT_W  shift factor s for this vector; legal range 0..4.
- in_valid  input  1  left_in, right_in and shift_in are valid.
- in_ready  output  1  stage can accept this cycle.
- msg_out  output  5*MSG_W  shifted vector; msg_out[k] = in[(k+s) mod 5].
- out_valid  output  1  msg_out is valid.
- out_ready  input  1  downstream accepts msg_out.
- shift_err  output  1  the vector now in the output register had s > 4.

Behaviour:
- Reset: rstn sampled low on a sys_clk edge clears stage valids, msg_out, out_valid and shift_err to 0. in_ready is 1 from the first cycle after reset.
- Reset mid-operation: all in-flight vectors are discarded. No partial output is produced.
- Handshake: a transfer occurs on a cycle where in_valid && in_ready, or out_valid && out_ready.
  - in_ready = !s0_valid || s1_advance.
  - s1_advance = !out_valid || out_ready.
  - Outputs hold stable while out_valid && !out_ready.
- Stage 0 (capture): on input transfer, register left_in, right_in and a 5-bit select mask. mask[k] = 1 (take left) iff k < 5-s and k <= 3. Also register err0 = (s > 4).
- Stage 1 (merge): when s0_valid && s1_advance:
  - msg_out[k] <= mask[k] ? left[k] : right[k].
  - If err0, msg_out <= 0 and shift_err <= 1; otherwise shift_err <= 0.
  - out_valid <= 1.
- When s1_advance and !s0_valid, out_valid <= 0.
- Latency: 2 cycles from input transfer to out_valid with no stall.
- Throughput: 1 vector per cycle while out_ready stays high.
- Simultaneous events: an input transfer and an output transfer in the same cycle both occur; no bubble is inserted.
- Stall depth: at most 2 vectors are held (s0 and output register). in_ready drops only when both are full and out_ready=0.
- Mask table:
  - s=0 -> 01111
  - s=1 -> 01111
  - s=2 -> 00111
  - s=3 -> 00011
  - s=4 -> 00001
  - (bit 4 is MSB)
- Illegal s (5..7): vector still consumes one slot and emits zeros with shift_err=1. No other state is affected.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with in_valid=1 -> out_valid=0, msg_out=0, shift_err=0; in_ready=1 on the first cycle after release.
- Full shift sweep (MSG_W=4, in = {4,3,2,1,0} as elements 4..0), s=0..4 back-to-back with out_ready=1:
  - s=0 -> msg_out {4,3,2,1,0}
  - s=1 -> {0,4,3,2,1}
  - s=2 -> {1,0,4,3,2}
  - s=3 -> {2,1,0,4,3}
  - s=4 -> {3,2,1,0,4}
  - Each appears exactly 2 cycles after its input; out_valid stays high for 5 consecutive cycles.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 with 3 distinct vectors -> in_ready drops after 2 accepted, msg_out holds the first vector. After out_ready=1, all 3 emerge in order with none lost or duplicated.
- Illegal shift: s=6 between two legal s=2 vectors -> outputs are s=2 result (shift_err=0), then 0 (shift_err=1), then s=2 result (shift_err=0).
- Reset mid-stream: assert rstn=0 with 2 vectors in flight -> out_valid=0 next cycle; after release, the first new input appears after 2 cycles with no stale data.
- Random: 10k vectors with random s (0..4), random in_valid/out_ready -> msg_out matches a cyclic-shift reference model and order is preserved.

Source files
------------

// File: rtl/qsn_merge_pc5.sv
// Output merge stage of the Pc=5 quasi-cyclic shift network.
// Picks left/right network elements per shift factor over two registered stages.
module qsn_merge_pc5 #(
  parameter int PC      = 5,
  parameter int MSG_W   = 1,
  parameter int SHIFT_W = 3
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  input  logic [(PC-1)*MSG_W-1:0]  left_in,
  input  logic [PC*MSG_W-1:0]      right_in,
  input  logic [SHIFT_W-1:0]       shift_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PC*MSG_W-1:0]      msg_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     shift_err
);

  logic                    s0_valid;
  logic [(PC-1)*MSG_W-1:0] s0_left;
  logic [PC*MSG_W-1:0]     s0_right;
  logic [PC-1:0]           s0_mask;
  logic                    s0_err;

  logic                    s1_advance;
  logic [PC-1:0]           mask;
  logic                    err;
  logic [PC*MSG_W-1:0]     left_ext;
  logic [PC*MSG_W-1:0]     merged;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s0_valid || s1_advance;
  assign err        = int'(shift_in) > PC - 1;

  // Left network only has PC-1 outputs, so the top element always comes from the right.
  always_comb begin
    mask = '0;
    for (int k = 0; k < PC; k++)
      mask[k] = (k < PC - 1) && (k + int'(shift_in) < PC);
  end

  assign left_ext = {{MSG_W{1'b0}}, s0_left};

  always_comb begin
    merged = '0;
    for (int k = 0; k < PC; k++)
      merged[k*MSG_W +: MSG_W] = s0_mask[k] ? left_ext[k*MSG_W +: MSG_W]
                                            : s0_right[k*MSG_W +: MSG_W];
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      s0_valid <= 1'b0;
      s0_left  <= '0;
      s0_right <= '0;
      s0_mask  <= '0;
      s0_err   <= 1'b0;
    end else if (in_valid && in_ready) begin
      s0_valid <= 1'b1;
      s0_left  <= left_in;
      s0_right <= right_in;
      s0_mask  <= mask;
      s0_err   <= err;
    end else if (s1_advance) begin
      s0_valid <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      msg_out   <= '0;
      out_valid <= 1'b0;
      shift_err <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s0_valid;
      if (s0_valid) begin
        msg_out   <= s0_err ? '0 : merged;
        shift_err <= s0_err;
      end
    end
  end

endmodule

// File: tb/tb_qsn_merge_pc5.sv
// Bench for qsn_merge_pc5 with MSG_W=4.
// Scoreboard queue plus directed reset, sweep, stall, illegal-shift and random phases.
module tb_qsn_merge_pc5;

  typedef struct packed {
    logic [19:0] msg;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [15:0] left_in;
  logic [19:0] right_in;
  logic [2:0]  shift_in;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] msg_out;
  logic        out_valid;
  logic        out_ready;
  logic        shift_err;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur;
  logic in_fire;
  logic out_fire;
  logic stall;
  logic [19:0] hold_msg;
  logic        hold_err;
  int   nout;

  qsn_merge_pc5 #(.PC(5), .MSG_W(4), .SHIFT_W(3)) dut (
    .sys_clk   (clk),
    .rstn      (rstn),
    .left_in   (left_in),
    .right_in  (right_in),
    .shift_in  (shift_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msg_out   (msg_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .shift_err (shift_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] ref_msg(input logic [19:0] v, input int s);
    logic [19:0] e;
    e = '0;
    if (s > 4) return e;
    for (int k = 0; k < 5; k++)
      e[k*4 +: 4] = v[((k + s) % 5)*4 +: 4];
    return e;
  endfunction

  task automatic build(input logic [19:0] v, input int s,
                       output logic [15:0] l, output logic [19:0] r);
    l = 16'($urandom);
    r = 20'($urandom);
    if (s <= 4) begin
      for (int k = 0; k < 4; k++)
        if (k < 5 - s) l[k*4 +: 4] = v[(k + s)*4 +: 4];
      for (int k = 0; k < 5; k++)
        if (k >= 5 - s) r[k*4 +: 4] = v[(k - (5 - s))*4 +: 4];
      if (s == 0) r[19:16] = v[19:16];
    end
  endtask

  task automatic drive(input logic [19:0] v, input int s);
    logic [15:0] l;
    logic [19:0] r;
    build(v, s, l, r);
    left_in  = l;
    right_in = r;
    shift_in = 3'(s);
    in_valid = 1'b1;
    cur.msg  = ref_msg(v, s);
    cur.err  = (s > 4);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample_now();
    exp_t e;
    #1;
    in_fire  = 1'b0;
    out_fire = 1'b0;
    if (!rstn) begin
      q.delete();
      stall = 1'b0;
      return;
    end
    if (stall) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_msg", 32'(msg_out), 32'(hold_msg));
      chk("hold_err", 32'(shift_err), 32'(hold_err));
    end
    if (out_valid && out_ready) begin
      out_fire = 1'b1;
      nout++;
      if (q.size() == 0) begin
        chk("out_without_input", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("msg_out", 32'(msg_out), 32'(e.msg));
        chk("shift_err", 32'(shift_err), 32'(e.err));
      end
    end
    stall    = out_valid && !out_ready;
    hold_msg = msg_out;
    hold_err = shift_err;
    if (in_valid && in_ready) begin
      in_fire = 1'b1;
      q.push_back(cur);
    end
  endtask

  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [19:0] sweep_v;
  logic [19:0] sweep_exp [5];
  logic [19:0] bp_v [3];
  int          bp_s [3];
  int          idx;
  int          sent;

  initial begin
    stall     = 1'b0;
    nout      = 0;
    rstn      = 1'b0;
    out_ready = 1'b1;
    drive(20'h5a5a5, 1);

    for (int c = 0; c < 3; c++) begin
      sample_now();
      if (c > 0) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_msg_out", 32'(msg_out), 32'd0);
        chk("rst_shift_err", 32'(shift_err), 32'd0);
      end
      next();
    end
    rstn     = 1'b1;
    in_valid = 1'b0;
    sample_now();
    chk("rst_out_valid_rel", 32'(out_valid), 32'd0);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    next();

    sweep_v      = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    sweep_exp[0] = 20'h43210;
    sweep_exp[1] = 20'h04321;
    sweep_exp[2] = 20'h10432;
    sweep_exp[3] = 20'h21043;
    sweep_exp[4] = 20'h32104;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) drive(sweep_v, c);
      else in_valid = 1'b0;
      sample_now();
      if (c < 5) chk("sweep_accept", 32'(in_fire), 32'd1);
      chk("sweep_valid", 32'(out_valid), (c >= 2 && c <= 6) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 6)
        chk("sweep_msg", 32'(msg_out), 32'(sweep_exp[c-2]));
      next();
    end

    bp_v[0] = 20'h13579; bp_s[0] = 1;
    bp_v[1] = 20'h2468a; bp_s[1] = 3;
    bp_v[2] = 20'hfedcb; bp_s[2] = 4;
    idx  = 0;
    nout = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (idx < 3) drive(bp_v[idx], bp_s[idx]);
      else in_valid = 1'b0;
      sample_now();
      chk("bp_in_ready", 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (c >= 2) chk("bp_hold_first", 32'(msg_out), 32'(ref_msg(bp_v[0], bp_s[0])));
      if (in_fire) idx++;
      next();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !(idx == 3 && q.size() == 0); c++) begin
      if (idx < 3) drive(bp_v[idx], bp_s[idx]);
      else in_valid = 1'b0;
      sample_now();
      if (in_fire) idx++;
      next();
    end
    chk("bp_all_sent", 32'(idx), 32'd3);
    chk("bp_drained", 32'(q.size()), 32'd0);
    chk("bp_out_count", 32'(nout), 32'd3);

    for (int c = 0; c < 7; c++) begin
      if (c == 0) drive(20'h97531, 2);
      else if (c == 1) drive(20'h11111, 6);
      else if (c == 2) drive(20'hc0ffe, 2);
      else in_valid = 1'b0;
      sample_now();
      if (c >= 2 && c <= 4) begin
        chk("illegal_valid", 32'(out_valid), 32'd1);
        chk("illegal_err_seq", 32'(shift_err), (c == 3) ? 32'd1 : 32'd0);
      end
      if (c == 3) chk("illegal_zero", 32'(msg_out), 32'd0);
      next();
    end
    chk("illegal_drained", 32'(q.size()), 32'd0);

    out_ready = 1'b0;
    drive(20'h0aaaa, 1);
    sample_now();
    next();
    drive(20'h0bbbb, 2);
    sample_now();
    next();
    rstn     = 1'b0;
    in_valid = 1'b0;
    sample_now();
    next();
    rstn      = 1'b1;
    out_ready = 1'b1;
    drive(20'h3cafe, 3);
    sample_now();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_accept", 32'(in_fire), 32'd1);
    next();
    in_valid = 1'b0;
    sample_now();
    chk("midrst_lat1", 32'(out_valid), 32'd0);
    next();
    sample_now();
    chk("midrst_lat2", 32'(out_valid), 32'd1);
    chk("midrst_msg", 32'(msg_out), 32'(ref_msg(20'h3cafe, 3)));
    next();
    sample_now();
    chk("midrst_no_stale", 32'(out_valid), 32'd0);
    next();

    sent = 0;
    for (int c = 0; c < 60000 && !(sent == 10000 && q.size() == 0); c++) begin
      if (sent < 10000 && $urandom_range(3) != 0)
        drive(20'($urandom), int'($urandom_range(4)));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(3) != 0);
      sample_now();
      if (in_fire) sent++;
      next();
    end
    chk("rand_sent", 32'(sent), 32'd10000);
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
